sram_obi_bridge: RTL and testbench

SRAM_OBI_BRIDGE -- requirements
Module: sram_obi_bridge

---
 rtl/sram_bridge_pkg.sv | 32 +++
 rtl/sram_bridge_resp_fifo.sv | 73 +++++++
 rtl/sram_obi_bridge.sv | 165 ++++++++++++++++
 tb/tb_sram_obi_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg
// Shared types and constants for the OBI-to-SRAM bridge.
//   resp_t          : one buffered OBI response {rdata, err}
//   RESP_DEPTH      : number of response buffer entries
//   BUS_DATA_WIDTH  : width of the response data field (bus width of this SoC)
//   next_resp_ptr() : wrapping increment for the response buffer pointers
package sram_bridge_pkg;

    localparam int BUS_DATA_WIDTH   = 32;
    localparam int RESP_DEPTH       = 2;
    localparam int RESP_COUNT_WIDTH = $clog2(RESP_DEPTH + 1);
    localparam int RESP_PTR_WIDTH   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef struct packed {
        logic [BUS_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } resp_t;

    localparam int RESP_WIDTH = $bits(resp_t);

    // Pointers wrap explicitly so the buffer stays correct even if
    // RESP_DEPTH is ever changed to a non-power-of-two.
    function automatic logic [RESP_PTR_WIDTH-1:0] next_resp_ptr(
        input logic [RESP_PTR_WIDTH-1:0] ptr
    );
        if (ptr == RESP_PTR_WIDTH'(RESP_DEPTH - 1)) begin
            return '0;
        end
        return ptr + RESP_PTR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sram_bridge_resp_fifo.sv
// sram_bridge_resp_fifo
// Small in-order response buffer used by sram_obi_bridge to hold OBI
// responses that the manager has not yet accepted.
// Ports:
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset, empties the buffer
//   push_i       : write push_data_i into the tail
//   push_data_i  : packed resp_t to store
//   pop_i        : drop the head entry
//   head_o       : packed resp_t at the head (valid when !empty_o)
//   count_o      : number of stored entries
//   full_o       : all entries occupied
//   empty_o      : no entries stored
module sram_bridge_resp_fifo
    import sram_bridge_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic [RESP_WIDTH-1:0]       push_data_i,
    input  logic                        pop_i,
    output logic [RESP_WIDTH-1:0]       head_o,
    output logic [RESP_COUNT_WIDTH-1:0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    resp_t                       mem_q [RESP_DEPTH];
    logic [RESP_PTR_WIDTH-1:0]   rd_ptr_q;
    logic [RESP_PTR_WIDTH-1:0]   wr_ptr_q;
    logic [RESP_COUNT_WIDTH-1:0] count_q;
    logic                        do_push;
    logic                        do_pop;

    // Status flags come straight from the occupancy counter. Popping an
    // empty buffer is ignored, and a push into a full buffer is only taken
    // when the head leaves in the same cycle, so the count never wraps.
    always_comb begin
        full_o  = (count_q == RESP_COUNT_WIDTH'(RESP_DEPTH));
        empty_o = (count_q == '0);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    // Storage, pointers and occupancy. A simultaneous push and pop moves
    // both pointers but leaves the count untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= resp_t'(push_data_i);
                wr_ptr_q        <= next_resp_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_resp_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + RESP_COUNT_WIDTH'(1);
                2'b01:   count_q <= count_q - RESP_COUNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_obi_bridge.sv
// sram_obi_bridge
// Bridges an OBI subordinate port onto port 0 of a single-cycle SRAM macro.
// Requests are granted while fewer than RESP_DEPTH responses are
// outstanding; the SRAM is driven combinationally in the grant cycle and the
// response appears one cycle later, either directly or from a 2-entry
// buffer when the manager stalls rready.
// Ports:
//   clk_i, rst_ni                     : clock, synchronous active-low reset
//   obi_req_i / obi_gnt_o             : address-phase handshake
//   obi_addr_i, obi_we_i, obi_be_i,
//   obi_wdata_i                       : address-phase payload (byte address)
//   obi_rvalid_o / obi_rready_i       : response-phase handshake
//   obi_rdata_o, obi_err_o            : response payload
//   sram_csb_o, sram_web_o            : active-low select / write enable
//   sram_wmask_o, sram_addr_o,
//   sram_din_o                        : SRAM write mask, word address, data
//   sram_dout_i                       : SRAM read data, valid the cycle after select
module sram_obi_bridge
    import sram_bridge_pkg::*;
#(
    parameter int          DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int          NUM_WMASKS = 4,
    parameter int          ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [31:0]           obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [NUM_WMASKS-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0] obi_wdata_i,

    output logic                  obi_rvalid_o,
    input  logic                  obi_rready_i,
    output logic [DATA_WIDTH-1:0] obi_rdata_o,
    output logic                  obi_err_o,

    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
);

    logic                        inflight_q;
    logic                        inflight_we_q;
    logic                        inflight_err_q;

    logic [32:0]                 addr_offset;
    logic                        in_range;
    logic                        accept;
    logic                        sram_sel;
    logic [RESP_COUNT_WIDTH-1:0] occupancy;

    resp_t                       live_resp;
    resp_t                       head_resp;
    resp_t                       out_resp;
    logic [RESP_WIDTH-1:0]       fifo_head;
    logic [RESP_COUNT_WIDTH-1:0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        retire;

    // Window decode. The subtraction is done one bit wider so an address
    // below BASE_ADDR borrows into bit 32; the request is in range only if
    // there is no borrow and the offset fits in the word-addressed window.
    always_comb begin
        addr_offset = {1'b0, obi_addr_i} - {1'b0, BASE_ADDR};
        in_range    = (addr_offset[32:ADDR_WIDTH+2] == '0);
    end

    // Address-phase handshake. Outstanding work is the response still in
    // flight plus whatever is parked in the buffer; capping that at the
    // buffer depth is what makes the buffer impossible to overflow. The
    // full flag is redundant with the occupancy test but keeps the guard
    // local to the buffer's own view. Nothing is granted while in reset.
    always_comb begin
        occupancy = fifo_count + RESP_COUNT_WIDTH'(inflight_q);
        obi_gnt_o = rst_ni && obi_req_i && !fifo_full &&
                    (occupancy < RESP_COUNT_WIDTH'(RESP_DEPTH));
        accept    = obi_gnt_o;
        sram_sel  = accept && in_range;
    end

    // SRAM port 0 follows the OBI request combinationally in the grant
    // cycle. Out-of-range requests are granted but never select the macro.
    // Unselected cycles drive idle values so the outputs stay quiet.
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = '0;
        sram_addr_o  = '0;
        sram_din_o   = '0;
        if (sram_sel) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = !obi_we_i;
            sram_wmask_o = obi_be_i;
            sram_addr_o  = obi_addr_i[ADDR_WIDTH+1:2];
            sram_din_o   = obi_wdata_i;
        end
    end

    // One-cycle inflight marker for the request accepted last cycle. It
    // remembers just enough (write vs read, error vs hit) to build the
    // response when the SRAM read data arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q     <= 1'b0;
            inflight_we_q  <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_we_q  <= obi_we_i;
                inflight_err_q <= !in_range;
            end
        end
    end

    // Response for the inflight request. Only a successful read carries
    // data; writes and decode errors return zero data.
    always_comb begin
        live_resp = '0;
        if (inflight_q) begin
            live_resp.err = inflight_err_q;
            if (!inflight_err_q && !inflight_we_q) begin
                live_resp.rdata = sram_dout_i;
            end
        end
    end

    // Response ordering. With an empty buffer the live response bypasses
    // straight to the outputs and only gets parked if the manager does not
    // take it this cycle. With a non-empty buffer the head is presented and
    // the live response always queues behind it to keep acceptance order.
    always_comb begin
        head_resp    = resp_t'(fifo_head);
        out_resp     = fifo_empty ? live_resp : head_resp;
        obi_rvalid_o = rst_ni && (!fifo_empty || inflight_q);
        obi_rdata_o  = rst_ni ? out_resp.rdata : '0;
        obi_err_o    = rst_ni && out_resp.err;
        retire       = obi_rvalid_o && obi_rready_i;
        fifo_pop     = retire && !fifo_empty;
        fifo_push    = inflight_q && !(fifo_empty && obi_rready_i);
    end

    sram_bridge_resp_fifo u_resp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push),
        .push_data_i (live_resp),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_obi_bridge.sv
// tb_sram_obi_bridge
// Self-checking bench for sram_obi_bridge: a behavioural SRAM answers the
// port-0 pins, a shadow memory predicts read data, and every expected OBI
// response is queued when its request is granted and compared when the
// bridge retires it.
module tb_sram_obi_bridge;

    localparam int          DW        = 32;
    localparam int          NM        = 4;
    localparam int          AW        = 11;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] WIN_BYTES = 32'd4 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          obi_req;
    logic          obi_gnt;
    logic [31:0]   obi_addr;
    logic          obi_we;
    logic [NM-1:0] obi_be;
    logic [DW-1:0] obi_wdata;
    logic          obi_rvalid;
    logic          obi_rready;
    logic [DW-1:0] obi_rdata;
    logic          obi_err;
    logic          sram_csb;
    logic          sram_web;
    logic [NM-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] shadow   [0:(1<<AW)-1];
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];

    int checks     = 0;
    int errors     = 0;
    int resp_count = 0;

    logic          obs_csb;
    logic          obs_web;
    logic [NM-1:0] obs_wmask;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_din;

    always #5 clk = ~clk;

    sram_obi_bridge #(
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NM),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .obi_req_i    (obi_req),
        .obi_gnt_o    (obi_gnt),
        .obi_addr_i   (obi_addr),
        .obi_we_i     (obi_we),
        .obi_be_i     (obi_be),
        .obi_wdata_i  (obi_wdata),
        .obi_rvalid_o (obi_rvalid),
        .obi_rready_i (obi_rready),
        .obi_rdata_o  (obi_rdata),
        .obi_err_o    (obi_err),
        .sram_csb_o   (sram_csb),
        .sram_web_o   (sram_web),
        .sram_wmask_o (sram_wmask),
        .sram_addr_o  (sram_addr),
        .sram_din_o   (sram_din),
        .sram_dout_i  (sram_dout)
    );

    // Behavioural single-port SRAM: masked write or registered read on select.
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < NM; b++) begin
                    if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    // Scoreboard: every retired response is compared against the oldest prediction.
    always @(negedge clk) begin
        if (obi_rvalid && obi_rready) begin
            exp_t e;
            resp_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL resp_unexpected got rdata=%h err=%b want no response", obi_rdata, obi_err);
            end else begin
                e = exp_q.pop_front();
                if (obi_rdata !== e.rdata || obi_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL resp_data got rdata=%h err=%b want rdata=%h err=%b",
                             obi_rdata, obi_err, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one request from posedge+1 until granted (bounded), capture the
    // SRAM pins in the grant cycle, predict the response, return at posedge+1.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [NM-1:0] be,
                         input logic [DW-1:0] wdata, output int waited);
        logic granted;
        logic hit;
        exp_t e;
        int   w;
        obi_req   = 1'b1;
        obi_addr  = addr;
        obi_we    = we;
        obi_be    = be;
        obi_wdata = wdata;
        granted   = 1'b0;
        waited    = 0;
        hit       = (addr >= BASE) && ((addr - BASE) < WIN_BYTES);
        w         = int'((addr - BASE) >> 2);
        while (!granted && waited < 8) begin
            @(negedge clk);
            if (obi_gnt) begin
                granted   = 1'b1;
                obs_csb   = sram_csb;
                obs_web   = sram_web;
                obs_wmask = sram_wmask;
                obs_addr  = sram_addr;
                obs_din   = sram_din;
                e.rdata   = '0;
                e.err     = !hit;
                if (hit && we) begin
                    for (int b = 0; b < NM; b++) begin
                        if (be[b]) shadow[w][b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end else if (hit) begin
                    e.rdata = shadow[w];
                end
                exp_q.push_back(e);
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!granted) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout addr=%h got no gnt want gnt within 8 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        obi_req = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        obi_req    = 1'b1;
        obi_we     = 1'b0;
        obi_addr   = 32'h10;
        obi_be     = '1;
        obi_wdata  = '0;
        obi_rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (obi_gnt !== 1'b0)    begin errors++; $display("[TB] FAIL reset_gnt got %b want 0", obi_gnt); end
        checks++; if (obi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got %b want 0", obi_rvalid); end
        checks++; if (obi_rdata !== '0)    begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", obi_rdata); end
        checks++; if (obi_err !== 1'b0)    begin errors++; $display("[TB] FAIL reset_err got %b want 0", obi_err); end
        checks++; if (sram_csb !== 1'b1)   begin errors++; $display("[TB] FAIL reset_csb got %b want 1", sram_csb); end
        checks++; if (sram_web !== 1'b1)   begin errors++; $display("[TB] FAIL reset_web got %b want 1", sram_web); end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        obi_req = 1'b0;
        @(negedge clk);
        checks++; if (obi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_rvalid got %b want 0", obi_rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int waited;
        issue(32'h10, 1'b1, 4'hF, 32'hA5A5_5A5A, waited);
        checks++; if (waited != 0)          begin errors++; $display("[TB] FAIL wr_gnt_wait got %0d want 0", waited); end
        checks++; if (obs_csb !== 1'b0)     begin errors++; $display("[TB] FAIL wr_csb got %b want 0", obs_csb); end
        checks++; if (obs_web !== 1'b0)     begin errors++; $display("[TB] FAIL wr_web got %b want 0", obs_web); end
        checks++; if (obs_addr !== 11'd4)   begin errors++; $display("[TB] FAIL wr_addr got %h want 4", obs_addr); end
        checks++; if (obs_wmask !== 4'hF)   begin errors++; $display("[TB] FAIL wr_wmask got %h want f", obs_wmask); end
        checks++; if (obs_din !== 32'hA5A5_5A5A) begin errors++; $display("[TB] FAIL wr_din got %h want a5a55a5a", obs_din); end
        issue(32'h10, 1'b0, 4'hF, 32'h0, waited);
        checks++; if (obs_csb !== 1'b0)     begin errors++; $display("[TB] FAIL rd_csb got %b want 0", obs_csb); end
        checks++; if (obs_web !== 1'b1)     begin errors++; $display("[TB] FAIL rd_web got %b want 1", obs_web); end
        checks++; if (obs_addr !== 11'd4)   begin errors++; $display("[TB] FAIL rd_addr got %h want 4", obs_addr); end
        obi_req = 1'b0;
        @(negedge clk);
        checks++; if (obi_rvalid !== 1'b1)  begin errors++; $display("[TB] FAIL rd_rvalid got %b want 1", obi_rvalid); end
        checks++; if (obi_rdata !== 32'hA5A5_5A5A) begin errors++; $display("[TB] FAIL rd_rdata got %h want a5a55a5a", obi_rdata); end
        @(posedge clk); #1;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int waited;
        int bubbles;
        int base_cnt;
        for (int i = 0; i < 8; i++) begin
            issue(32'h100 + 32'(i) * 4, 1'b1, 4'hF, 32'h1000_0000 + 32'(i) * 32'h0101_0101, waited);
        end
        idle(3);
        base_cnt = resp_count;
        bubbles  = 0;
        for (int i = 0; i < 8; i++) begin
            issue(32'h100 + 32'(i) * 4, 1'b0, 4'hF, 32'h0, waited);
            bubbles += waited;
        end
        checks++; if (bubbles != 0) begin errors++; $display("[TB] FAIL b2b_gnt_bubbles got %0d want 0", bubbles); end
        checks++; if (resp_count - base_cnt != 7) begin errors++; $display("[TB] FAIL b2b_resp_by_cycle8 got %0d want 7", resp_count - base_cnt); end
        obi_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (resp_count - base_cnt != 8) begin errors++; $display("[TB] FAIL b2b_resp_by_cycle9 got %0d want 8", resp_count - base_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_pending got %0d want 0", exp_q.size()); end
        idle(1);
    endtask

    task automatic test_backpressure();
        int            idx;
        int            grants;
        int            waited;
        logic          last_gnt;
        logic          seen;
        logic          stable;
        logic [DW-1:0] held;
        exp_t          e;
        obi_rready = 1'b0;
        idx        = 0;
        grants     = 0;
        seen       = 1'b0;
        stable     = 1'b1;
        held       = '0;
        last_gnt   = 1'b0;
        obi_req    = 1'b1;
        obi_we     = 1'b0;
        obi_be     = 4'hF;
        obi_addr   = 32'h100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            last_gnt = obi_gnt;
            if (obi_gnt) begin
                e.rdata = shadow[(32'h100 >> 2) + idx];
                e.err   = 1'b0;
                exp_q.push_back(e);
                grants++;
                idx++;
            end
            if (seen && (obi_rvalid !== 1'b1 || obi_rdata !== held)) stable = 1'b0;
            if (!seen && obi_rvalid === 1'b1) begin
                seen = 1'b1;
                held = obi_rdata;
            end
            @(posedge clk); #1;
            obi_addr = 32'h100 + 32'(idx) * 4;
        end
        checks++; if (grants != 2)       begin errors++; $display("[TB] FAIL bp_grants got %0d want 2", grants); end
        checks++; if (last_gnt !== 1'b0) begin errors++; $display("[TB] FAIL bp_gnt_low got %b want 0", last_gnt); end
        checks++; if (stable !== 1'b1)   begin errors++; $display("[TB] FAIL bp_stable got %b want 1", stable); end
        checks++; if (held !== 32'h1000_0000) begin errors++; $display("[TB] FAIL bp_head got %h want 10000000", held); end
        obi_rready = 1'b1;
        issue(obi_addr, 1'b0, 4'hF, 32'h0, waited);
        checks++; if (waited != 1) begin errors++; $display("[TB] FAIL bp_resume_wait got %0d want 1", waited); end
        idle(4);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_error();
        int waited;
        issue(BASE + 32'h2000, 1'b0, 4'hF, 32'h0, waited);
        checks++; if (waited != 0)      begin errors++; $display("[TB] FAIL err_gnt_wait got %0d want 0", waited); end
        checks++; if (obs_csb !== 1'b1) begin errors++; $display("[TB] FAIL err_csb got %b want 1", obs_csb); end
        obi_req = 1'b0;
        @(negedge clk);
        checks++; if (obi_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL err_rvalid got %b want 1", obi_rvalid); end
        checks++; if (obi_err !== 1'b1)    begin errors++; $display("[TB] FAIL err_flag got %b want 1", obi_err); end
        checks++; if (obi_rdata !== '0)    begin errors++; $display("[TB] FAIL err_rdata got %h want 0", obi_rdata); end
        @(posedge clk); #1;
        issue(BASE + 32'h1FFC, 1'b1, 4'hF, 32'hCAFE_F00D, waited);
        checks++; if (obs_csb !== 1'b0)    begin errors++; $display("[TB] FAIL top_word_csb got %b want 0", obs_csb); end
        checks++; if (obs_addr !== 11'h7FF) begin errors++; $display("[TB] FAIL top_word_addr got %h want 7ff", obs_addr); end
        issue(BASE + 32'h1FFC, 1'b0, 4'hF, 32'h0, waited);
        issue(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, waited);
        checks++; if (obs_csb !== 1'b1)    begin errors++; $display("[TB] FAIL high_addr_csb got %b want 1", obs_csb); end
        idle(3);
    endtask

    task automatic test_partial_write();
        int waited;
        issue(32'h20, 1'b1, 4'hF, 32'hDEAD_BEEF, waited);
        issue(32'h20, 1'b1, 4'b0010, 32'h1122_3344, waited);
        checks++; if (obs_wmask !== 4'b0010) begin errors++; $display("[TB] FAIL pw_wmask got %b want 0010", obs_wmask); end
        checks++; if (obs_web !== 1'b0)      begin errors++; $display("[TB] FAIL pw_web got %b want 0", obs_web); end
        issue(32'h20, 1'b0, 4'hF, 32'h0, waited);
        obi_req = 1'b0;
        @(negedge clk);
        checks++; if (obi_rdata !== 32'hDEAD_33EF) begin errors++; $display("[TB] FAIL pw_merge got %h want dead33ef", obi_rdata); end
        @(posedge clk); #1;
        idle(2);
    endtask

    task automatic test_reset_mid();
        int   waited;
        int   grants;
        exp_t e;
        obi_rready = 1'b0;
        grants     = 0;
        obi_req    = 1'b1;
        obi_we     = 1'b0;
        obi_be     = 4'hF;
        obi_addr   = 32'h100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (obi_gnt) begin
                grants++;
                e.rdata = shadow[(32'h100 >> 2) + c];
                e.err   = 1'b0;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            obi_addr = 32'h104;
        end
        checks++; if (grants != 2) begin errors++; $display("[TB] FAIL rm_grants got %0d want 2", grants); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (obi_gnt !== 1'b0)    begin errors++; $display("[TB] FAIL rm_gnt got %b want 0", obi_gnt); end
        checks++; if (obi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rm_rvalid got %b want 0", obi_rvalid); end
        checks++; if (sram_csb !== 1'b1)   begin errors++; $display("[TB] FAIL rm_csb got %b want 1", sram_csb); end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        obi_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++; if (obi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rm_after_rvalid got %b want 0", obi_rvalid); end
        @(posedge clk); #1;
        obi_rready = 1'b1;
        issue(32'h104, 1'b0, 4'hF, 32'h0, waited);
        obi_req = 1'b0;
        @(negedge clk);
        checks++; if (obi_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rm_read_rvalid got %b want 1", obi_rvalid); end
        checks++; if (obi_rdata !== 32'h1101_0101) begin errors++; $display("[TB] FAIL rm_read_rdata got %h want 11010101", obi_rdata); end
        @(posedge clk); #1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_partial_write();
        test_reset_mid();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
